// File: rtl/sweep_controller_pkg.sv
// Shared encodings for the sweep sequencer: FSM states and the status-phase codes
// also shown by the calculator's top-level status display.
package sweep_controller_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOADMAX = 3'd1,
    LOADCNT = 3'd2,
    UP      = 3'd3,
    DOWN    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [1:0] PHASE_IDLE = 2'd0;
  localparam logic [1:0] PHASE_LOAD = 2'd1;
  localparam logic [1:0] PHASE_UP   = 2'd2;
  localparam logic [1:0] PHASE_DOWN = 2'd3;

  function automatic logic [1:0] phase_of(input state_t s);
    case (s)
      LOADMAX, LOADCNT: phase_of = PHASE_LOAD;
      UP:               phase_of = PHASE_UP;
      DOWN:             phase_of = PHASE_DOWN;
      default:          phase_of = PHASE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sweep_controller_bounded_counter.sv
// Unsigned up/down counter bounded to [0, max]; never wraps.
// Priority: clr > ldmax > ldcnt > up > down.
module bounded_counter #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         up,
  input  logic         down,
  input  logic         ldcnt,
  input  logic         ldmax,
  input  logic [N-1:0] in,
  output logic [N-1:0] count,
  output logic [N-1:0] max
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      max   <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (ldmax) begin
      max <= in;
    end else if (ldcnt) begin
      count <= (in > max) ? max : in;
    end else if (up) begin
      if (count < max) count <= count + 1'b1;
    end else if (down) begin
      if (count != '0) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/sweep_controller.sv
// Sweep sequencer: loads ceiling/start into a bounded counter, then sweeps it
// up to the ceiling and back to zero a programmed number of times.
module sweep_controller
  import sweep_controller_pkg::*;
#(
  parameter int N     = 5,
  parameter int CYC_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic [N-1:0]     cfg_max,
  input  logic [N-1:0]     cfg_start,
  input  logic [CYC_W-1:0] cfg_cycles,
  output logic [N-1:0]     count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted,
  output logic [1:0]       phase,
  output logic [CYC_W-1:0] cycles_left
);

  state_t         state, nxt;
  logic [N-1:0]   max_q, start_q, cnt_in, cnt_max;
  logic           clr, up, down, ldcnt, ldmax;
  logic           abort_go, accept;

  bounded_counter #(.N(N)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .up    (up),
    .down  (down),
    .ldcnt (ldcnt),
    .ldmax (ldmax),
    .in    (cnt_in),
    .count (count),
    .max   (cnt_max)
  );

  assign accept   = (state == IDLE) && start && (cfg_max != '0);
  assign abort_go = abort && (state inside {LOADMAX, LOADCNT, UP, DOWN});

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    nxt    = state;
    clr    = 1'b0;
    ldmax  = 1'b0;
    ldcnt  = 1'b0;
    up     = 1'b0;
    down   = 1'b0;
    cnt_in = max_q;
    case (state)
      IDLE:    if (accept) nxt = LOADMAX;
      LOADMAX: begin
        ldmax = 1'b1;
        nxt   = LOADCNT;
      end
      LOADCNT: begin
        ldcnt  = 1'b1;
        cnt_in = (start_q > max_q) ? max_q : start_q;
        nxt    = UP;
      end
      UP: if (!pause) begin
        if (count < cnt_max) up = 1'b1;
        else begin
          down = 1'b1;
          nxt  = DOWN;
        end
      end
      DOWN: if (!pause) begin
        if (count != '0) down = 1'b1;
        else if (cycles_left > CYC_W'(1)) begin
          up  = 1'b1;
          nxt = UP;
        end else nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // Abort overrides pause and any normal transition.
    if (abort_go) begin
      nxt   = IDLE;
      clr   = 1'b1;
      ldmax = 1'b0;
      ldcnt = 1'b0;
      up    = 1'b0;
      down  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      max_q       <= '0;
      start_q     <= '0;
      cycles_left <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      aborted     <= 1'b0;
      phase       <= PHASE_IDLE;
    end else begin
      state   <= nxt;
      busy    <= nxt inside {LOADMAX, LOADCNT, UP, DOWN};
      done    <= (nxt == DONE);
      phase   <= phase_of(nxt);
      err     <= (state == IDLE) && start && (cfg_max == '0);
      aborted <= abort_go;
      if (accept) begin
        max_q       <= cfg_max;
        start_q     <= cfg_start;
        cycles_left <= (cfg_cycles == '0) ? CYC_W'(1) : cfg_cycles;
      end else if (abort_go || nxt == DONE) begin
        cycles_left <= '0;
      end else if (state == DOWN && nxt == UP) begin
        cycles_left <= cycles_left - CYC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sweep_controller.sv
// Scoreboard bench for sweep_controller: stimulus queues hand-computed per-cycle
// expectations; a monitor compares them after the matching clock edge.
module tb_sweep_controller;

  localparam int N = 5, CYC_W = 4;

  logic             clk = 1'b0, rst = 1'b1;
  logic             start = 1'b0, abort = 1'b0, pause = 1'b0;
  logic [N-1:0]     cfg_max = '0, cfg_start = '0;
  logic [CYC_W-1:0] cfg_cycles = '0;
  logic [N-1:0]     count;
  logic             busy, done, err, aborted;
  logic [1:0]       phase;
  logic [CYC_W-1:0] cycles_left;

  sweep_controller #(.N(N), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
    .cfg_max(cfg_max), .cfg_start(cfg_start), .cfg_cycles(cfg_cycles),
    .count(count), .busy(busy), .done(done), .err(err), .aborted(aborted),
    .phase(phase), .cycles_left(cycles_left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]     count;
    logic             busy, done, err, aborted;
    logic [1:0]       phase;
    logic [CYC_W-1:0] cl;
  } exp_t;

  typedef struct {
    int    cyc;
    string tag;
    exp_t  e;
  } sb_t;

  sb_t   sb[$];
  int    cyc_n  = 0;
  int    n_cmp  = 0;
  int    n_bad  = 0;
  string cur_tag = "reset";

  function automatic exp_t mk(int c, bit b, bit d, bit er, bit ab, int ph, int cl);
    mk = '{count: N'(c), busy: b, done: d, err: er, aborted: ab, phase: 2'(ph), cl: CYC_W'(cl)};
  endfunction

  localparam exp_t ZERO = '{default: '0};

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  always @(posedge clk) cyc_n++;

  // Monitor: compare every expectation whose target edge has passed.
  always @(posedge clk) begin
    exp_t act;
    #2;
    act = '{count: count, busy: busy, done: done, err: err, aborted: aborted,
            phase: phase, cl: cycles_left};
    while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
      sb_t s;
      s = sb.pop_front();
      n_cmp++;
      if (act !== s.e) begin
        n_bad++;
        $display("FAIL %s @cyc%0d: got count=%0d busy=%0b done=%0b err=%0b aborted=%0b phase=%0d cl=%0d, required count=%0d busy=%0b done=%0b err=%0b aborted=%0b phase=%0d cl=%0d",
                 s.tag, s.cyc, act.count, act.busy, act.done, act.err, act.aborted, act.phase, act.cl,
                 s.e.count, s.e.busy, s.e.done, s.e.err, s.e.aborted, s.e.phase, s.e.cl);
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic drive(input bit s, input bit a, input bit p, input exp_t e);
    start = s; abort = a; pause = p;
    sb.push_back('{cyc: cyc_n + 1, tag: cur_tag, e: e});
    @(posedge clk); #1;
  endtask

  task automatic tick(input exp_t e);
    drive(1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic cfg(input int m, input int s, input int c);
    cfg_max = N'(m); cfg_start = N'(s); cfg_cycles = CYC_W'(c);
  endtask

  int c1[9]  = '{2, 3, 4, 5, 4, 3, 2, 1, 0};
  int p1[9]  = '{2, 2, 2, 2, 3, 3, 3, 3, 3};
  int c2[13] = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};
  int p2[13] = '{2, 2, 2, 2, 3, 3, 3, 2, 2, 2, 3, 3, 3};
  int l2[13] = '{2, 2, 2, 2, 2, 2, 2, 1, 1, 1, 1, 1, 1};
  int c3[5]  = '{4, 3, 2, 1, 0};
  int p3[5]  = '{2, 3, 3, 3, 3};
  int c4[5]  = '{4, 3, 2, 1, 0};
  int p4[5]  = '{2, 3, 3, 3, 3};

  initial begin
    #12;
    check("reset_count", int'(count), 0);
    check("reset_busy",  int'(busy), 0);
    check("reset_phase", int'(phase), 0);
    check("reset_cl",    int'(cycles_left), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Single sweep 2 -> 5 -> 0.
    cur_tag = "sweep1";
    cfg(5, 2, 1);
    drive(1'b1, 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 1, 1));
    tick(mk(0, 1, 0, 0, 0, 1, 1));
    foreach (c1[i]) tick(mk(c1[i], 1, 0, 0, 0, p1[i], 1));
    tick(mk(0, 0, 1, 0, 0, 0, 0));
    tick(ZERO);

    // Two sweeps 0 -> 3 -> 0.
    cur_tag = "sweep2";
    cfg(3, 0, 2);
    drive(1'b1, 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 1, 2));
    tick(mk(0, 1, 0, 0, 0, 1, 2));
    foreach (c2[i]) tick(mk(c2[i], 1, 0, 0, 0, p2[i], l2[i]));
    tick(mk(0, 0, 1, 0, 0, 0, 0));
    tick(ZERO);

    // Start above max clamps; zero cycles means one; abort in DONE is not reported.
    cur_tag = "clamp";
    cfg(4, 9, 0);
    drive(1'b1, 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 1, 1));
    tick(mk(0, 1, 0, 0, 0, 1, 1));
    foreach (c3[i]) tick(mk(c3[i], 1, 0, 0, 0, p3[i], 1));
    tick(mk(0, 0, 1, 0, 0, 0, 0));
    cur_tag = "abort_in_done";
    drive(1'b0, 1'b1, 1'b0, ZERO);

    // Zero ceiling is rejected.
    cur_tag = "err";
    cfg(0, 3, 2);
    drive(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 1, 0, 0, 0));
    tick(ZERO);

    // Pause at count 3 for four cycles; start during the sweep is ignored.
    cur_tag = "pause";
    cfg(4, 1, 1);
    drive(1'b1, 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 1, 1));
    tick(mk(0, 1, 0, 0, 0, 1, 1));
    for (int i = 1; i <= 3; i++) tick(mk(i, 1, 0, 0, 0, 2, 1));
    for (int i = 0; i < 4; i++) drive(i == 1, 1'b0, 1'b1, mk(3, 1, 0, 0, 0, 2, 1));
    foreach (c4[i]) tick(mk(c4[i], 1, 0, 0, 0, p4[i], 1));
    tick(mk(0, 0, 1, 0, 0, 0, 0));
    tick(ZERO);

    // Abort at count 2 in DOWN.
    cur_tag = "abort_down";
    cfg(3, 3, 1);
    drive(1'b1, 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 1, 1));
    tick(mk(0, 1, 0, 0, 0, 1, 1));
    tick(mk(3, 1, 0, 0, 0, 2, 1));
    tick(mk(2, 1, 0, 0, 0, 3, 1));
    drive(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 1, 0, 0));
    tick(ZERO);

    // Start and abort together in IDLE: start wins; then abort in LOADMAX.
    cur_tag = "start_abort";
    cfg(6, 2, 5);
    drive(1'b1, 1'b1, 1'b0, mk(0, 1, 0, 0, 0, 1, 5));
    drive(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 1, 0, 0));
    tick(ZERO);

    // Async reset mid-UP.
    cur_tag = "async_rst";
    cfg(5, 0, 3);
    drive(1'b1, 1'b0, 1'b0, mk(0, 1, 0, 0, 0, 1, 3));
    tick(mk(0, 1, 0, 0, 0, 1, 3));
    for (int i = 0; i <= 2; i++) tick(mk(i, 1, 0, 0, 0, 2, 3));
    #2 rst = 1'b1;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_busy",  int'(busy), 0);
    check("arst_phase", int'(phase), 0);
    check("arst_cl",    int'(cycles_left), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    tick(ZERO);

    repeat (3) @(posedge clk);
    #4;
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/sweep_controller.md
Name: sweep_controller

Overview:
- Sequencer for the calculator's bounded up/down counter datapath.
- On a start request it loads a ceiling value and a start value into the counter. It then drives the counter up to the ceiling and back down to zero, repeating a programmed number of times.
- It reports busy/done/phase to the calculator control logic.
- Owns one bounded counter instance; count value exported for display/datapath use.

Parameters:
N, 5, counter/data width in bits
CYC_W, 4, width of repeat-count field

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a sweep; sampled only in IDLE
abort  input  1  synchronous cancel; valid in any non-IDLE state
pause  input  1  freeze counting in UP/DOWN (state and count held)
cfg_max  input  N  ceiling value, captured on accepted start
cfg_start  input  N  initial count, captured on accepted start
cfg_cycles  input  CYC_W  number of up/down sweeps; 0 treated as 1
count  output  N  current counter value
busy  output  1  high in LOADMAX, LOADCNT, UP, DOWN
done  output  1  one-cycle pulse on normal completion
err  output  1  one-cycle pulse when start is rejected (cfg_max==0)
aborted  output  1  one-cycle pulse after abort taken
phase  output  2  0 idle/done, 1 loading, 2 up, 3 down
cycles_left  output  CYC_W  sweeps remaining, including the current one

Behaviour:
- Reset (async, any time, including mid-sweep): state=IDLE. count=0, counter max=0, captured config=0, cycles_left=0. busy=done=err=aborted=0, phase=0.
- States: IDLE, LOADMAX, LOADCNT, UP, DOWN, DONE.
- IDLE:
  - start=1 and cfg_max!=0 -> capture cfg_max, cfg_start, and cycles=(cfg_cycles==0?1:cfg_cycles); go to LOADMAX.
  - start=1 and cfg_max==0 -> err pulse next cycle; stay IDLE; counter untouched.
- LOADMAX (1 cycle): drive counter ldmax with the captured max -> LOADCNT.
- LOADCNT (1 cycle): drive ldcnt with min(start_q, max_q) -> UP. A start value above max is clamped to max.
- UP, each unpaused cycle:
  - count<max: assert up.
  - count==max: assert down, go to DOWN. The turnaround costs no dead cycle; max is visible for exactly 1 cycle.
- DOWN, each unpaused cycle:
  - count>0: assert down.
  - count==0 and cycles_left>1: decrement cycles_left, assert up, go to UP.
  - count==0 and cycles_left==1: cycles_left->0, go to DONE.
- DONE (1 cycle): done=1, busy=0 -> IDLE. The count stays at 0.
- pause=1 in UP/DOWN: no up/down asserted; state, count and cycles_left held. pause is ignored in other states.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; counter cleared synchronously (count=0); cycles_left=0; aborted pulses 1 cycle.
  - abort takes priority over pause and over normal transitions.
  - abort in DONE: done still pulses; no aborted pulse.
- start while not IDLE is ignored. start and abort together in IDLE: start wins (abort has no meaning in IDLE).
- Latency: accepted start at edge E0 -> max loaded at E1 -> count=start at E2 -> first increment at E3.
- Arithmetic: unsigned N-bit throughout. The counter saturates at 0 and max and never wraps. Comparisons are unsigned.

Decomposition:
- Shared package: state encoding localparams (IDLE..DONE) and PHASE_IDLE/LOAD/UP/DOWN codes, both reused by the calculator top-level status display.
- One sub-module: bounded_counter.
  - Ports: clk, rst (async), clr (sync), up, down, ldcnt, ldmax, in[N] -> count[N], max[N].
  - Priority: clr > ldmax > ldcnt > up > down.
  - Saturates at 0 and max; ldcnt clamps to max.
- The controller is a pure FSM driving that instance.

Test Plan:
- max=5, start=2, cycles=1, start pulse -> busy 1 at E1. Count after E2..: 2,3,4,5,4,3,2,1,0. done pulses the cycle after count reaches 0, then IDLE with count=0.
- max=3, start=0, cycles=2 -> count 0,1,2,3,2,1,0,1,2,3,2,1,0. cycles_left 2 until the first zero, then 1; single done pulse.
- max=4, start=9 (clamped), cycles=0 (->1) -> count 4,3,2,1,0 then done. cfg_max=0 with start -> err pulse, busy stays 0.
- Mid-UP at count=3, pause held 4 cycles -> count stays 3, phase=2. On release, counting resumes at 4. start pulsed during the sweep is ignored.
- Abort at count=2 in DOWN -> next cycle IDLE, count=0, aborted pulse, no done. Async rst asserted mid-UP -> immediately IDLE, count=0, busy=0.
